// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith/compare operations plus iterative
// unsigned multiply (shift-add) and divide (restoring shift-subtract).
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       Card,
    input  logic [SHW-1:0]   Shft,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] R
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_SUB  = 6'b100010;
    localparam logic [5:0] OP_AND  = 6'b100100;
    localparam logic [5:0] OP_OR   = 6'b100101;
    localparam logic [5:0] OP_XOR  = 6'b100110;
    localparam logic [5:0] OP_MOVZ = 6'b001010;
    localparam logic [5:0] OP_SLL  = 6'b000000;
    localparam logic [5:0] OP_CMP  = 6'b111110;
    localparam logic [5:0] OP_MUL  = 6'b011000;
    localparam logic [5:0] OP_DIVU = 6'b011011;

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   op_b_r;
    logic               is_div_r;
    logic [WIDTH-1:0]   f_r;
    logic [WIDTH-1:0]   r_r;
    logic               out_valid_r;

    logic [WIDTH-1:0]   alu_f_s;
    logic [4:0]         flags_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     sum_s;
    logic               ge_s;
    logic [2*WIDTH-1:0] step_s;

    assign in_ready  = !rst && (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign F         = f_r;
    assign R         = r_r;

    // Single-cycle operation result
    always_comb begin
        flags_s[0] = (A == B);
        flags_s[1] = ($signed(A) < $signed(B));
        flags_s[2] = (A < B);
        flags_s[3] = flags_s[1] | flags_s[0];
        flags_s[4] = flags_s[2] | flags_s[0];
        alu_f_s    = {WIDTH{1'b0}};
        case (Card)
            OP_ADD:  alu_f_s = A + B;
            OP_SUB:  alu_f_s = A - B;
            OP_AND:  alu_f_s = A & B;
            OP_OR:   alu_f_s = A | B;
            OP_XOR:  alu_f_s = A ^ B;
            OP_MOVZ: alu_f_s = A;
            OP_SLL:  alu_f_s = B << Shft;
            OP_CMP:  alu_f_s = {{(WIDTH-10){1'b0}}, ~flags_s, flags_s};
            default: alu_f_s = {WIDTH{1'b0}};
        endcase
    end

    // One multiply or divide iteration; acc holds {high/remainder, low/quotient}
    always_comb begin
        trial_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        ge_s    = (trial_s >= {1'b0, op_b_r});
        sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, op_b_r} : {(WIDTH+1){1'b0}});
        if (is_div_r) begin
            if (ge_s) begin
                step_s = {trial_s[WIDTH-1:0] - op_b_r, acc_r[WIDTH-2:0], 1'b1};
            end else begin
                step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Handshake state machine and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            is_div_r    <= 1'b0;
            f_r         <= {WIDTH{1'b0}};
            r_r         <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (Card == OP_MUL || Card == OP_DIVU) begin
                            // Divide shifts the dividend out of the low half; multiply shifts B out
                            is_div_r <= (Card == OP_DIVU);
                            acc_r    <= {{WIDTH{1'b0}}, (Card == OP_DIVU) ? A : B};
                            op_b_r   <= (Card == OP_DIVU) ? B : A;
                            cnt_r    <= CW'(WIDTH);
                            state_r  <= ST_BUSY;
                        end else begin
                            f_r         <= alu_f_s;
                            r_r         <= {WIDTH{1'b0}};
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end
                    end
                end
                ST_BUSY: begin
                    acc_r <= step_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        f_r         <= step_s[WIDTH-1:0];
                        r_r         <= step_s[2*WIDTH-1:WIDTH];
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed, table-driven bench for seq_alu (WIDTH=32) with hand-computed results.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [5:0]  Card;
    logic [4:0]  Shft;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] F;
    logic [31:0] R;

    int n_vec = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Card(Card), .Shft(Shft),
        .out_valid(out_valid), .out_ready(out_ready), .F(F), .R(R)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  card;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  shft;
        logic [31:0] exp_f;
        logic [31:0] exp_r;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one operation, measure latency, check results, then drain it
    task automatic run_op(input vec_t v, input bit noise);
        int wait_cnt;
        int lat;
        bit ready_seen;
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        chk({v.name, "_in_ready_wait"}, 32'(wait_cnt < 50), 32'd1);
        A = v.a; B = v.b; Card = v.card; Shft = v.shft;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D; Shft = 5'd7;
        lat = 0;
        ready_seen = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            if (noise) begin
                in_valid = 1'b1;
                Card = 6'b100000;
            end
            tick();
            lat++;
        end
        if (in_ready) ready_seen = 1'b1;
        in_valid = 1'b0;
        chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, "_in_ready_low"}, 32'(ready_seen), 32'd0);
        chk({v.name, "_F"}, F, v.exp_f);
        chk({v.name, "_R"}, R, v.exp_r);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({v.name, "_drained"}, 32'(out_valid), 32'd0);
        chk({v.name, "_in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{"add_ovf",  6'b100000, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 32'h0, 0};
        vecs[1]  = '{"sub_neg",  6'b100010, 32'h00000005, 32'h00000007, 5'd0, 32'hFFFFFFFE, 32'h0, 0};
        vecs[2]  = '{"and",      6'b100100, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 32'h0, 0};
        vecs[3]  = '{"or",       6'b100101, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFFF0FFF0, 32'h0, 0};
        vecs[4]  = '{"xor",      6'b100110, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 32'h0, 0};
        vecs[5]  = '{"movz",     6'b001010, 32'h12345678, 32'h00000009, 5'd0, 32'h12345678, 32'h0, 0};
        vecs[6]  = '{"sll4",     6'b000000, 32'h00000001, 32'h0000000F, 5'd4, 32'h000000F0, 32'h0, 0};
        vecs[7]  = '{"cmp_split",6'b111110, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h000002AA, 32'h0, 0};
        // Equal operands: eq, signed <=, unsigned <= set; complements of signed < and unsigned < set
        vecs[8]  = '{"cmp_eq",   6'b111110, 32'h80000000, 32'h80000000, 5'd0, 32'h000000D9, 32'h0, 0};
        vecs[9]  = '{"cmp_lt",   6'b111110, 32'h00000001, 32'h00000002, 5'd0, 32'h0000003E, 32'h0, 0};
        vecs[10] = '{"illegal",  6'b111111, 32'h00000001, 32'h00000002, 5'd0, 32'h00000000, 32'h0, 0};
        vecs[11] = '{"mul_max",  6'b011000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h00000001, 32'hFFFFFFFE, 32};
        vecs[12] = '{"divu",     6'b011011, 32'd100,      32'd7,        5'd0, 32'd14,        32'd2,        32};
        vecs[13] = '{"divu_z",   6'b011011, 32'd5,        32'd0,        5'd0, 32'hFFFFFFFF, 32'd5,        32};
        vecs[14] = '{"divu_big", 6'b011011, 32'hFFFFFFFF, 32'd10,       5'd0, 32'h19999999, 32'd5,        32};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = 32'h0; B = 32'h0; Card = 6'b0; Shft = 5'd0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_F", F, 32'h0);
        chk("rst_R", R, 32'h0);
        chk("rst_in_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", 32'(in_ready), 32'd1);

        for (int i = 0; i < 15; i++) run_op(vecs[i], 1'b0);

        // ADD overflow with out_ready held high: exactly one valid cycle
        out_ready = 1'b1;
        A = 32'hFFFFFFFF; B = 32'h1; Card = 6'b100000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("add_hold_valid", 32'(out_valid), 32'd1);
        chk("add_hold_F", F, 32'h0);
        chk("add_hold_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("add_hold_valid_fall", 32'(out_valid), 32'd0);
        chk("add_hold_in_ready_back", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        // MUL with stray in_valid pulses while busy; no extra result afterwards
        v = '{"mul_noise", 6'b011000, 32'h00010000, 32'h00010001, 5'd0, 32'h00010000, 32'h00000001, 32};
        run_op(v, 1'b1);
        tick();
        tick();
        chk("mul_noise_no_extra", 32'(out_valid), 32'd0);

        // Backpressure on SLL result
        A = 32'h0; B = 32'h1; Shft = 5'd31; Card = 6'b000000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_F", F, 32'h80000000);
            chk("bp_R", R, 32'h0);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drain", 32'(out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(in_ready), 32'd1);

        // Reset in the middle of a multiply
        A = 32'h00010000; B = 32'h00010001; Card = 6'b011000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_F", F, 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        v = '{"add_after_rst", 6'b100000, 32'd3, 32'd4, 5'd0, 32'd7, 32'd0, 0};
        run_op(v, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                n_err++;
                $display("FAIL midrst_stale: got out_valid 1 expected 0");
            end
            tick();
        end
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
